camera_frame_capture: RTL
=========================

CAMERA_FRAME_CAPTURE -- requirements
Module: camera_frame_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 clk  input  1: single clock, the camera pixel clock; all logic rises on it.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 vsyn  input  1: camera frame sync; high = vertical blanking.
REQ-006 href  input  1: camera line valid; high = data byte valid this cycle.
REQ-007 camera_data  input  8: camera byte, RGB565, high byte first.
REQ-008 pause  input  1: high = do not start capturing new frames.
REQ-009 wren  output  1: one-cycle write strobe to the frame RAM.
REQ-010 camera_color_write  output  12: RGB444 pixel, {R[3:0],G[3:0],B[3:0]}.
REQ-011 store_addr  output  19: frame RAM address of camera_color_write.
REQ-012 frame_done  output  1: one-cycle pulse at the end of each captured frame.
REQ-013 frame_count  output  8: count of captured frames.
REQ-014 overflow  output  1: sticky flag, frame delivered more than H_ACTIVE*V_ACTIVE pixels.

Function
REQ-015 The FSM SHALL have the states WAIT_VS, SYNC, CAPTURE and SKIP.
REQ-016 WAIT_VS: wait for vsyn high, then go to SYNC. This prevents a partial first frame after reset.
REQ-017 SYNC: on a vsyn falling edge (previous sample 1, current 0), go to CAPTURE if pause=0, else to SKIP.
REQ-018 CAPTURE: on a vsyn rising edge, pulse frame_done for 1 cycle, increment frame_count (wraps 255->0), and go to SYNC.
REQ-019 SKIP: ignore all bytes; on a vsyn rising edge, go to SYNC with no frame_done pulse.
REQ-020 pause changing mid-frame SHALL NOT abort the frame in progress; pause is sampled only at frame start.
REQ-021 In CAPTURE, a byte-phase bit SHALL toggle on each cycle with href=1, and SHALL clear whenever href=0.
  - The odd trailing byte of a line is discarded.
REQ-022 Phase 0 byte SHALL be latched as the high byte; a phase 1 byte completes the pixel.
REQ-023 Pixel conversion: R=hi[7:4], G={hi[2:0],lo[7]}, B=lo[4:1].
REQ-024 Outputs SHALL be registered: wren, camera_color_write and store_addr are valid together on the cycle after the phase-1 byte is sampled (latency 1).
REQ-025 store_addr SHALL be 0 for the first pixel of a frame and increment by 1 after each write.
REQ-026 A column counter SHALL run 0..H_ACTIVE-1 in step with the pixel writes and clear on href=0.
REQ-027 Pixels beyond address H_ACTIVE*V_ACTIVE-1 (307199) SHALL be dropped (wren=0), store_addr SHALL hold, and overflow SHALL set.
REQ-028 store_addr and the column counter SHALL reset to 0 on each vsyn falling edge.
REQ-029 overflow SHALL clear on each vsyn falling edge.
REQ-030 wren SHALL be 0 in every state other than CAPTURE.
REQ-031 If vsyn rises and a phase-1 byte arrives in the same cycle, that pixel SHALL still be written before frame_done.

Reset
REQ-032 rst SHALL force the state to WAIT_VS.
REQ-033 rst SHALL force wren=0, camera_color_write=0, store_addr=0, frame_done=0, frame_count=0, overflow=0, byte phase=0 and the column counter to 0.
REQ-034 rst mid-frame SHALL discard the rest of that frame; capture resumes only after a full vsyn high-to-low sequence.

Configuration
REQ-035 With macro CAPTURE_TEST_PATTERN_EN defined, camera_color_write SHALL come from 8 vertical bars, each H_ACTIVE/8 columns wide, selected by the column counter.
  - Bar colours, left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Timing, wren and addresses SHALL be unchanged; camera_data is ignored.
REQ-036 Without CAPTURE_TEST_PATTERN_EN, camera_color_write SHALL be the converted camera pixel and no pattern logic SHALL be synthesised.

Verification
REQ-037 Reset, then vsyn 1->0, then href=1 with bytes F8,00 -> one wren with camera_color_write=F00 and store_addr=0, one cycle after the 00 byte.
REQ-038 Full 640x480 frame, then vsyn rising -> 307200 wren pulses, last store_addr=307199, one frame_done pulse, frame_count=1, overflow=0.
REQ-039 pause=1 at vsyn falling, then a full frame -> zero wren and no frame_done; pause=1 raised mid-frame -> frame completes normally.
REQ-040 Line of 3 bytes (07,E0,AA) then href=0 -> one pixel written with value 0F0; AA discarded; phase=0 at the next line start.
REQ-041 Frame of 481 lines -> the extra 640 pixels are not written, store_addr holds at 307199, overflow=1, then clears at the next vsyn falling edge.
REQ-042 With CAPTURE_TEST_PATTERN_EN defined, one line -> pixels 0..79=FFF, 80..159=FF0, ..., 560..639=000; rst mid-line -> wren=0 until the next frame start.

Source files
------------

// File: rtl/camera_frame_capture.sv
// -----------------------------------------------------------------------------
// camera_frame_capture
//
// Captures RGB565 bytes from a parallel camera (OV7670 style: vsyn/href/data,
// high byte first) and converts each pixel to RGB444 for a frame RAM.
// Pixels are written at consecutive addresses starting at 0 each frame.
// Capture begins only after a complete vsyn high-to-low sequence has been
// seen. The pause input is sampled only at the start of a frame.
//
// Optional feature: defining CAPTURE_TEST_PATTERN_EN replaces the camera
// pixel with 8 vertical colour bars chosen by the column counter. Timing,
// wren and addresses do not change in that mode.
//
// Parameters
//   H_ACTIVE           active pixels per line
//   V_ACTIVE           active lines per frame
// Ports
//   clk                camera pixel clock
//   rst                synchronous, active-high reset
//   vsyn               frame sync, high = vertical blanking
//   href               line valid, high = camera_data valid
//   camera_data[7:0]   RGB565 byte stream, high byte first
//   pause              high = do not start capturing new frames
//   wren               one-cycle frame RAM write strobe
//   camera_color_write RGB444 pixel {R,G,B}
//   store_addr[18:0]   frame RAM address of camera_color_write
//   frame_done         one-cycle pulse after each captured frame
//   frame_count[7:0]   captured frames, wraps 255 -> 0
//   overflow           sticky: frame delivered more than H_ACTIVE*V_ACTIVE px
// -----------------------------------------------------------------------------
module camera_frame_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsyn,
    input  logic        href,
    input  logic [7:0]  camera_data,
    input  logic        pause,
    output logic        wren,
    output logic [11:0] camera_color_write,
    output logic [18:0] store_addr,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        overflow
);

    localparam int          COL_W    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [19:0] TOTAL_C  = 20'(H_ACTIVE * V_ACTIVE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2,
        SKIP    = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             vsyn_d_r;
    logic             vs_fall_s;
    logic             vs_rise_s;
    logic             phase_r;
    logic [7:0]       hi_r;
    logic [COL_W-1:0] col_r;
    // One wider than store_addr so it can hold the "all pixels written" value.
    logic [19:0]      addr_next_r;
    logic             byte_hi_s;
    logic             pixel_s;
    logic [11:0]      conv_s;
    logic [11:0]      pix_s;
    logic             done_pend_r;
    logic             wren_r;
    logic [11:0]      color_r;
    logic [18:0]      store_addr_r;
    logic             frame_done_r;
    logic [7:0]       frame_count_r;
    logic             overflow_r;
    logic             unused_s;

    assign vs_fall_s = vsyn_d_r & ~vsyn;
    assign vs_rise_s = ~vsyn_d_r & vsyn;
    assign byte_hi_s = (state_r == CAPTURE) & href & ~phase_r;
    assign pixel_s   = (state_r == CAPTURE) & href & phase_r;

    // RGB565 -> RGB444: keep the top bits of each channel.
    assign conv_s   = {hi_r[7:4], hi_r[2:0], camera_data[7], camera_data[4:1]};
    assign unused_s = ^{hi_r[3], camera_data[6:5], camera_data[0]};

`ifdef CAPTURE_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [COL_W-1:0] bar_full_s;
    logic [2:0]       bar_s;

    function automatic logic [11:0] bar_color(input logic [2:0] bar);
        logic [11:0] c;
        case (bar)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    // Bar index from the column of the pixel being completed, clamped to 7.
    always_comb begin
        bar_full_s = col_r / COL_W'(BAR_W);
        if (bar_full_s > COL_W'(7)) begin
            bar_s = 3'd7;
        end else begin
            bar_s = bar_full_s[2:0];
        end
        pix_s = bar_color(bar_s);
    end
`else
    assign pix_s = conv_s;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_VS;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; pause is only looked at on the frame-start edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            WAIT_VS: begin
                if (vsyn) begin
                    state_s = SYNC;
                end else begin
                    state_s = WAIT_VS;
                end
            end
            SYNC: begin
                if (vs_fall_s) begin
                    state_s = pause ? SKIP : CAPTURE;
                end else begin
                    state_s = SYNC;
                end
            end
            CAPTURE: begin
                if (vs_rise_s) begin
                    state_s = SYNC;
                end else begin
                    state_s = CAPTURE;
                end
            end
            SKIP: begin
                if (vs_rise_s) begin
                    state_s = SYNC;
                end else begin
                    state_s = SKIP;
                end
            end
            default: state_s = WAIT_VS;
        endcase
    end

    // Byte assembly, address/column counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsyn_d_r      <= 1'b0;
            phase_r       <= 1'b0;
            hi_r          <= 8'd0;
            col_r         <= '0;
            addr_next_r   <= 20'd0;
            wren_r        <= 1'b0;
            color_r       <= 12'd0;
            store_addr_r  <= 19'd0;
            done_pend_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_count_r <= 8'd0;
            overflow_r    <= 1'b0;
        end else begin
            vsyn_d_r <= vsyn;
            wren_r   <= 1'b0;

            // Phase toggles per valid byte; a gap in href realigns to the
            // high byte, so an odd trailing byte is simply dropped.
            if ((state_r == CAPTURE) && href) begin
                phase_r <= ~phase_r;
            end else begin
                phase_r <= 1'b0;
            end

            if (byte_hi_s) begin
                hi_r <= camera_data;
            end

            if (pixel_s) begin
                col_r <= (col_r == COL_LAST) ? '0 : col_r + 1'b1;
                if (addr_next_r < TOTAL_C) begin
                    wren_r       <= 1'b1;
                    color_r      <= pix_s;
                    store_addr_r <= addr_next_r[18:0];
                    addr_next_r  <= addr_next_r + 20'd1;
                end else begin
                    // Frame RAM is full: drop the pixel, hold the address.
                    overflow_r <= 1'b1;
                end
            end else if (!href) begin
                col_r <= '0;
            end

            if (vs_fall_s) begin
                addr_next_r  <= 20'd0;
                store_addr_r <= 19'd0;
                col_r        <= '0;
                overflow_r   <= 1'b0;
            end

            // frame_done lags the sync edge by one extra cycle so a pixel
            // completed on that same edge is written first.
            done_pend_r  <= (state_r == CAPTURE) & vs_rise_s;
            frame_done_r <= done_pend_r;
            if (done_pend_r) begin
                frame_count_r <= frame_count_r + 8'd1;
            end
        end
    end

    assign wren               = wren_r;
    assign camera_color_write = color_r;
    assign store_addr         = store_addr_r;
    assign frame_done         = frame_done_r;
    assign frame_count        = frame_count_r;
    assign overflow           = overflow_r;

endmodule
